jump_ctrl: RTL and testbench

- Next-PC control stage directly upstream of the program counter; drives its absjump_en and target inputs.
- Decodes the per-instruction control op, resolves conditional branches against cond_flag and looks up absolute targets in a constant LUT.
- Maintains a small return-address stack (RAS) for CALL/RET and a RUN/HALTED state machine that freezes the PC on HALT.

---
 rtl/jump_pkg.sv | 34 +++
 rtl/ras_stack.sv | 58 +++++
 rtl/jump_ctrl.sv | 135 +++++++++++++
 tb/tb_jump_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared types and constants for the next-PC control stage: op and FSM encodings,
// default widths and the constant absolute branch-target table.
package jump_pkg;

    localparam int JC_D         = 9;
    localparam int JC_PC_W      = JC_D + 1;
    localparam int JC_LUT_W     = 5;
    localparam int JC_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRT  = 3'd2,
        OP_BRF  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6,
        OP_BRR  = 3'd7
    } ctrl_op_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } jc_state_t;

    // Entry i holds the absolute target 0x010 * (i + 1).
    localparam logic [JC_PC_W-1:0] BRANCH_LUT [2**JC_LUT_W] = '{
        10'h010, 10'h020, 10'h030, 10'h040, 10'h050, 10'h060, 10'h070, 10'h080,
        10'h090, 10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 10'h0E0, 10'h0F0, 10'h100,
        10'h110, 10'h120, 10'h130, 10'h140, 10'h150, 10'h160, 10'h170, 10'h180,
        10'h190, 10'h1A0, 10'h1B0, 10'h1C0, 10'h1D0, 10'h1E0, 10'h1F0, 10'h200
    };

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO: push is dropped when full, pop is ignored when empty.
// Entries and occupancy clear asynchronously on reset.
module ras_stack
    import jump_pkg::*;
#(
    parameter int W     = JC_PC_W,
    parameter int DEPTH = JC_RAS_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [AW-1:0] top_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign top_idx = AW'(count_q - CW'(1));
    assign top     = mem_q[top_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[count_q[AW-1:0]] = push_data;
            count_d                = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Next-PC control: decodes the control op into absjump_en/target, manages the
// return-address stack and the RUN/HALTED FSM. Define REL_JUMP_EN to build BRR.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int D         = JC_D,
    parameter int LUT_W     = JC_LUT_W,
    parameter int RAS_DEPTH = JC_RAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [D:0]                   prog_ctr,
    input  logic [2:0]                   op,
    input  logic                         cond_flag,
    input  logic [LUT_W-1:0]             lut_idx,
    input  logic [7:0]                   rel_off,
    output logic                         absjump_en,
    output logic [D:0]                   target,
    output logic                         halted,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PC_W = D + 1;

    jc_state_t         state_q, state_d;
    logic              ras_ovf_q, ras_ovf_d;
    logic              ras_unf_q, ras_unf_d;
    logic              push, pop, ras_full, ras_empty;
    logic [PC_W-1:0]   ras_top;
    logic [PC_W-1:0]   lut_target;
    logic [PC_W-1:0]   return_addr;

    assign lut_target  = PC_W'(BRANCH_LUT[lut_idx]);
    assign return_addr = prog_ctr + PC_W'(1);

`ifndef REL_JUMP_EN
    logic unused_rel_off;
    assign unused_rel_off = ^rel_off;
`endif

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (return_addr),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Outputs are combinational so the PC loads the target on the very next edge.
    always_comb begin
        absjump_en = 1'b0;
        target     = '0;
        push       = 1'b0;
        pop        = 1'b0;
        state_d    = state_q;
        ras_ovf_d  = ras_ovf_q;
        ras_unf_d  = ras_unf_q;
        if (!reset) begin
            if (state_q == HALTED) begin
                absjump_en = 1'b1;
                target     = prog_ctr;
            end else begin
                case (ctrl_op_t'(op))
                    OP_JMP: begin
                        absjump_en = 1'b1;
                        target     = lut_target;
                    end
                    OP_BRT: begin
                        absjump_en = cond_flag;
                        target     = lut_target;
                    end
                    OP_BRF: begin
                        absjump_en = !cond_flag;
                        target     = lut_target;
                    end
                    OP_CALL: begin
                        absjump_en = 1'b1;
                        target     = lut_target;
                        push       = 1'b1;
                        if (ras_full) ras_ovf_d = 1'b1;
                    end
                    OP_RET: begin
                        if (!ras_empty) begin
                            absjump_en = 1'b1;
                            target     = ras_top;
                            pop        = 1'b1;
                        end else begin
                            ras_unf_d = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        absjump_en = 1'b1;
                        target     = prog_ctr;
                        state_d    = HALTED;
                    end
`ifdef REL_JUMP_EN
                    OP_BRR: begin
                        absjump_en = cond_flag;
                        target     = prog_ctr + PC_W'($signed(rel_off));
                    end
`endif
                    default: begin
                        absjump_en = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            ras_ovf_q <= 1'b0;
            ras_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ras_ovf_q <= ras_ovf_d;
            ras_unf_q <= ras_unf_d;
        end
    end

    assign halted  = (state_q == HALTED);
    assign ras_ovf = ras_ovf_q;
    assign ras_unf = ras_unf_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed self-checking bench for jump_ctrl; BRR expectations follow REL_JUMP_EN.
module tb_jump_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] prog_ctr;
    logic [2:0] op;
    logic       cond_flag;
    logic [4:0] lut_idx;
    logic [7:0] rel_off;
    logic       absjump_en;
    logic [9:0] target;
    logic       halted;
    logic       ras_ovf;
    logic       ras_unf;
    logic [2:0] ras_count;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HALT = 3'd6, BRR = 3'd7;

    always #5 clk = ~clk;

    jump_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .prog_ctr   (prog_ctr),
        .op         (op),
        .cond_flag  (cond_flag),
        .lut_idx    (lut_idx),
        .rel_off    (rel_off),
        .absjump_en (absjump_en),
        .target     (target),
        .halted     (halted),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf),
        .ras_count  (ras_count)
    );

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [9:0] pc, input logic c,
                                 input logic [4:0] idx, input logic [7:0] off);
        op        = o;
        prog_ctr  = pc;
        cond_flag = c;
        lut_idx   = idx;
        rel_off   = off;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] ret_expect [4];

    initial begin
        reset = 1'b1;
        applyStimulus(HALT, 10'h123, 1'b1, 5'd3, 8'h00);
        checkOutput("reset_abs_forced", 16'(absjump_en), 16'h0);
        checkOutput("reset_tgt_forced", 16'(target), 16'h000);
        tick();
        tick();
        reset = 1'b0;

        applyStimulus(NOP, 10'h005, 1'b0, 5'd0, 8'h00);
        checkOutput("nop_abs", 16'(absjump_en), 16'h0);
        checkOutput("nop_halted", 16'(halted), 16'h0);
        checkOutput("nop_count", 16'(ras_count), 16'h0);
        checkOutput("nop_ovf", 16'(ras_ovf), 16'h0);
        checkOutput("nop_unf", 16'(ras_unf), 16'h0);
        tick();

        applyStimulus(JMP, 10'h005, 1'b0, 5'd3, 8'h00);
        checkOutput("jmp_abs", 16'(absjump_en), 16'h1);
        checkOutput("jmp_tgt", 16'(target), 16'h040);
        tick();
        applyStimulus(BRT, 10'h006, 1'b0, 5'd3, 8'h00);
        checkOutput("brt_c0_abs", 16'(absjump_en), 16'h0);
        applyStimulus(BRT, 10'h006, 1'b1, 5'd0, 8'h00);
        checkOutput("brt_c1_abs", 16'(absjump_en), 16'h1);
        checkOutput("brt_c1_tgt", 16'(target), 16'h010);
        applyStimulus(BRF, 10'h006, 1'b0, 5'd3, 8'h00);
        checkOutput("brf_c0_abs", 16'(absjump_en), 16'h1);
        checkOutput("brf_c0_tgt", 16'(target), 16'h040);
        applyStimulus(BRF, 10'h006, 1'b1, 5'd31, 8'h00);
        checkOutput("brf_c1_abs", 16'(absjump_en), 16'h0);
        tick();

        applyStimulus(CALL, 10'h010, 1'b0, 5'd5, 8'h00);
        checkOutput("call_abs", 16'(absjump_en), 16'h1);
        checkOutput("call_tgt", 16'(target), 16'h060);
        tick();
        checkOutput("call_count", 16'(ras_count), 16'h1);
        applyStimulus(RET, 10'h045, 1'b0, 5'd0, 8'h00);
        checkOutput("ret_abs", 16'(absjump_en), 16'h1);
        checkOutput("ret_tgt", 16'(target), 16'h011);
        tick();
        checkOutput("ret_count", 16'(ras_count), 16'h0);

        // Five CALLs into a four-deep stack; the first return address wraps to 0.
        ret_expect = '{10'h041, 10'h031, 10'h021, 10'h000};
        applyStimulus(CALL, 10'h3FF, 1'b0, 5'd7, 8'h00);
        checkOutput("call1_tgt", 16'(target), 16'h080);
        tick();
        applyStimulus(CALL, 10'h020, 1'b0, 5'd7, 8'h00);
        tick();
        applyStimulus(CALL, 10'h030, 1'b0, 5'd7, 8'h00);
        tick();
        applyStimulus(CALL, 10'h040, 1'b0, 5'd7, 8'h00);
        tick();
        checkOutput("full_count", 16'(ras_count), 16'h4);
        checkOutput("full_no_ovf", 16'(ras_ovf), 16'h0);
        applyStimulus(CALL, 10'h050, 1'b0, 5'd7, 8'h00);
        checkOutput("call5_abs", 16'(absjump_en), 16'h1);
        checkOutput("call5_tgt", 16'(target), 16'h080);
        tick();
        checkOutput("ovf_count", 16'(ras_count), 16'h4);
        checkOutput("ovf_set", 16'(ras_ovf), 16'h1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(RET, 10'h100, 1'b0, 5'd0, 8'h00);
            checkOutput($sformatf("lifo_abs%0d", i), 16'(absjump_en), 16'h1);
            checkOutput($sformatf("lifo_tgt%0d", i), 16'(target), 16'(ret_expect[i]));
            tick();
        end
        checkOutput("empty_count", 16'(ras_count), 16'h0);
        checkOutput("pre_unf", 16'(ras_unf), 16'h0);
        applyStimulus(RET, 10'h100, 1'b0, 5'd0, 8'h00);
        checkOutput("unf_abs", 16'(absjump_en), 16'h0);
        tick();
        checkOutput("unf_set", 16'(ras_unf), 16'h1);
        checkOutput("ovf_sticky", 16'(ras_ovf), 16'h1);
        checkOutput("unf_count", 16'(ras_count), 16'h0);

        applyStimulus(CALL, 10'h0AA, 1'b0, 5'd1, 8'h00);
        tick();
        applyStimulus(HALT, 10'h1FF, 1'b0, 5'd0, 8'h00);
        checkOutput("halt_abs", 16'(absjump_en), 16'h1);
        checkOutput("halt_tgt", 16'(target), 16'h1FF);
        checkOutput("halt_not_yet", 16'(halted), 16'h0);
        tick();
        checkOutput("halted_set", 16'(halted), 16'h1);
        applyStimulus(JMP, 10'h1FF, 1'b1, 5'd3, 8'h00);
        checkOutput("hjmp_abs", 16'(absjump_en), 16'h1);
        checkOutput("hjmp_tgt", 16'(target), 16'h1FF);
        applyStimulus(CALL, 10'h1FF, 1'b0, 5'd3, 8'h00);
        checkOutput("hcall_tgt", 16'(target), 16'h1FF);
        tick();
        checkOutput("hcall_count", 16'(ras_count), 16'h1);
        applyStimulus(RET, 10'h1FF, 1'b0, 5'd0, 8'h00);
        checkOutput("hret_tgt", 16'(target), 16'h1FF);
        tick();
        checkOutput("hret_count", 16'(ras_count), 16'h1);
        applyStimulus(NOP, 10'h050, 1'b0, 5'd0, 8'h00);
        checkOutput("htrack_tgt", 16'(target), 16'h050);

        // Async reset pulse entirely between clock edges.
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_halted", 16'(halted), 16'h0);
        checkOutput("arst_count", 16'(ras_count), 16'h0);
        checkOutput("arst_ovf", 16'(ras_ovf), 16'h0);
        checkOutput("arst_unf", 16'(ras_unf), 16'h0);
        checkOutput("arst_abs", 16'(absjump_en), 16'h0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("post_arst_abs", 16'(absjump_en), 16'h0);
        tick();

        // CALL presented while reset spans the edge leaves nothing on the stack.
        applyStimulus(CALL, 10'h010, 1'b0, 5'd2, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(NOP, 10'h010, 1'b0, 5'd0, 8'h00);
        checkOutput("rst_call_count", 16'(ras_count), 16'h0);
        tick();

        applyStimulus(BRR, 10'h002, 1'b1, 5'd3, 8'hFC);
`ifdef REL_JUMP_EN
        checkOutput("brr_back_abs", 16'(absjump_en), 16'h1);
        checkOutput("brr_back_tgt", 16'(target), 16'h3FE);
        applyStimulus(BRR, 10'h3FE, 1'b1, 5'd3, 8'h05);
        checkOutput("brr_fwd_tgt", 16'(target), 16'h003);
`else
        checkOutput("brr_nop_abs", 16'(absjump_en), 16'h0);
`endif
        applyStimulus(BRR, 10'h002, 1'b0, 5'd3, 8'hFC);
        checkOutput("brr_c0_abs", 16'(absjump_en), 16'h0);
        tick();
        checkOutput("brr_count", 16'(ras_count), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
